// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and helpers for the mips instruction/data memory
package mips_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_t;

    // Source of a registered read result presented to the core.
    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_RAM    = 2'd1,
        SEL_POISON = 2'd2
    } rd_sel_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;
    localparam logic [31:0] POISON_WORD       = 32'hDEAD_BEEF;

    // Word-aligned and inside [base, base+span); addresses below base wrap to a huge offset.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
        return ((addr - base) < span) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mips_memory_if.sv
// rtl/mips_memory_if.sv - core/preload bus between the mips core side and the memory
interface mips_memory_if;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic        data_rd_wr;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        mem_ready;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr;

    modport master (
        output instr_addr, data_rd_wr, data_addr, data_out,
               load_valid, load_addr, load_data, err_clr,
        input  instr_in, data_in, load_ready, mem_ready, err, err_addr
    );

    modport slave (
        input  instr_addr, data_rd_wr, data_addr, data_out,
               load_valid, load_addr, load_data, err_clr,
        output instr_in, data_in, load_ready, mem_ready, err, err_addr
    );
endinterface

// File: rtl/mips_mem_array.sv
// rtl/mips_mem_array.sv - word RAM, read-only port A, read plus write port B
module mips_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    output logic [31:0]   a_rdata,
    input  logic [AW-1:0] b_raddr,
    output logic [31:0]   b_rdata,
    input  logic          b_we,
    input  logic [AW-1:0] b_waddr,
    input  logic [31:0]   b_wdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Synchronous reads sample the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_raddr];
        if (b_we) begin
            mem[b_waddr] <= b_wdata;
        end
    end

endmodule

// File: rtl/mips_memory.sv
// rtl/mips_memory.sv - instruction/data memory responder with preload, zero-fill and error capture
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mips_memory_if.slave bus
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN        = 32'(DEPTH_WORDS * 4);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH_WORDS - 1);
    localparam mem_state_t  RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    mem_state_t    state;
    mem_state_t    state_nxt;
    logic          run;
    logic [AW-1:0] clr_cnt;
    rd_sel_t       instr_sel_q;
    rd_sel_t       data_sel_q;
    logic          err_q;
    logic [31:0]   err_addr_q;

    logic          instr_ok;
    logic          data_ok;
    logic          load_ok;
    logic [AW-1:0] instr_idx;
    logic [AW-1:0] data_idx;
    logic [AW-1:0] load_idx;
    logic          core_wr;
    logic          load_fire;

    logic [31:0]   a_rdata;
    logic [31:0]   b_rdata;
    logic          b_we;
    logic [AW-1:0] b_waddr;
    logic [31:0]   b_wdata;

    logic          err_hit;
    logic [31:0]   err_at;

    // mem_ready is a flop so it reads 0 during reset even when the block resets straight into RUN.
    assign run = bus.mem_ready;

    assign instr_ok  = addr_ok(bus.instr_addr, BASE_ADDR, SPAN);
    assign data_ok   = addr_ok(bus.data_addr,  BASE_ADDR, SPAN);
    assign load_ok   = addr_ok(bus.load_addr,  BASE_ADDR, SPAN);
    assign instr_idx = AW'((bus.instr_addr - BASE_ADDR) >> 2);
    assign data_idx  = AW'((bus.data_addr  - BASE_ADDR) >> 2);
    assign load_idx  = AW'((bus.load_addr  - BASE_ADDR) >> 2);

    // A core write owns port B, so the preload stream is stalled whenever the core writes.
    assign core_wr        = run & ~bus.data_rd_wr;
    assign bus.load_ready = run & bus.data_rd_wr;
    assign load_fire      = bus.load_valid & bus.load_ready;

    mips_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .a_addr  (instr_idx),
        .a_rdata (a_rdata),
        .b_raddr (data_idx),
        .b_rdata (b_rdata),
        .b_we    (b_we),
        .b_waddr (b_waddr),
        .b_wdata (b_wdata)
    );

    // Port B write arbitration: zero-fill sweep, then core write, then preload.
    always_comb begin
        b_we    = 1'b0;
        b_waddr = clr_cnt;
        b_wdata = '0;
        if (state == CLEAR) begin
            b_we = 1'b1;
        end else if (core_wr) begin
            b_we    = data_ok;
            b_waddr = data_idx;
            b_wdata = bus.data_out;
        end else if (load_fire) begin
            b_we    = load_ok;
            b_waddr = load_idx;
            b_wdata = bus.load_data;
        end
    end

    // Highest-priority access error this cycle: data, then load, then instruction.
    always_comb begin
        err_hit = 1'b0;
        err_at  = '0;
        if (run) begin
            if (!data_ok) begin
                err_hit = 1'b1;
                err_at  = bus.data_addr;
            end else if (load_fire && !load_ok) begin
                err_hit = 1'b1;
                err_at  = bus.load_addr;
            end else if (!instr_ok) begin
                err_hit = 1'b1;
                err_at  = bus.instr_addr;
            end
        end
    end

    // Sweep finishes once the last word has been written.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == LAST_IDX) begin
            state_nxt = RUN;
        end
    end

    // FSM, sweep counter and ready flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RESET_STATE;
            clr_cnt       <= '0;
            bus.mem_ready <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.mem_ready <= (state_nxt == RUN);
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Track where each read result comes from; writes and the sweep return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_sel_q <= SEL_ZERO;
            data_sel_q  <= SEL_ZERO;
        end else begin
            if (!run) begin
                instr_sel_q <= SEL_ZERO;
            end else begin
                instr_sel_q <= instr_ok ? SEL_RAM : SEL_POISON;
            end
            if (!run || !bus.data_rd_wr) begin
                data_sel_q <= SEL_ZERO;
            end else begin
                data_sel_q <= data_ok ? SEL_RAM : SEL_POISON;
            end
        end
    end

    // Sticky error; a new error in the clear cycle beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (err_hit) begin
            err_q      <= 1'b1;
            err_addr_q <= err_at;
        end else if (bus.err_clr) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end
    end

    assign bus.instr_in = (instr_sel_q == SEL_RAM)    ? a_rdata     :
                          (instr_sel_q == SEL_POISON) ? POISON_WORD : '0;
    assign bus.data_in  = (data_sel_q == SEL_RAM)     ? b_rdata     :
                          (data_sel_q == SEL_POISON)  ? POISON_WORD : '0;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_mips_memory.sv
// tb/tb_mips_memory.sv - directed scoreboard bench for mips_memory
module tb_mips_memory;

    localparam logic [31:0] BASE = 32'h8002_0000;

    typedef struct {
        bit          is_data;
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    mips_memory_if bus ();

    mips_memory #(
        .DEPTH_WORDS    (16),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int i);
        return BASE + 32'(i * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_data, input string tag, input logic [31:0] val);
        exp_t e;
        e.is_data = is_data;
        e.tag     = tag;
        e.val     = val;
        sb.push_back(e);
    endtask

    // Every read pushed before an edge is due one cycle later.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, e.is_data ? bus.data_in : bus.instr_in, e.val);
        end
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (!bus.mem_ready && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] val);
        bus.load_valid = 1'b1;
        bus.load_addr  = addr;
        bus.load_data  = val;
        #1;
        chk("load_ready", 32'(bus.load_ready), 32'd1);
        step();
        bus.load_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.instr_addr = BASE;
        bus.data_rd_wr = 1'b1;
        bus.data_addr  = BASE;
        bus.data_out   = '0;
        bus.load_valid = 1'b0;
        bus.load_addr  = BASE;
        bus.load_data  = '0;
        bus.err_clr    = 1'b0;
        reset          = 1'b0;
        step();
        step();
        chk("rst_mem_ready",  32'(bus.mem_ready),  32'd0);
        chk("rst_instr_in",   bus.instr_in,        32'd0);
        chk("rst_data_in",    bus.data_in,         32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_err",        32'(bus.err),        32'd0);
        chk("rst_err_addr",   bus.err_addr,        32'd0);

        // Zero-fill sweep length and contents
        reset = 1'b1;
        wait_clear("t1_clear_len");
        for (int i = 0; i < 16; i++) begin
            bus.data_addr  = w(i);
            bus.instr_addr = w(15 - i);
            push(1'b1, "t1_data_zero",  32'd0);
            push(1'b0, "t1_instr_zero", 32'd0);
            step();
        end
        bus.instr_addr = BASE;
        bus.data_addr  = BASE;

        // Preload
        load_word(BASE,  32'h2402_0005);
        load_word(w(2),  32'h2222_2222);
        load_word(w(15), 32'hCAFE_F00D);
        push(1'b0, "t2_preload_instr", 32'h2402_0005);
        step();

        // Core write stalls a concurrent preload
        bus.data_rd_wr = 1'b0;
        bus.data_addr  = w(4);
        bus.data_out   = 32'h1234_5678;
        bus.load_valid = 1'b1;
        bus.load_addr  = w(3);
        bus.load_data  = 32'hBBBB_BBBB;
        #1;
        chk("t3_load_stalled", 32'(bus.load_ready), 32'd0);
        push(1'b1, "t3_data_in_after_wr", 32'd0);
        push(1'b0, "t3_instr_during_wr",  32'h2402_0005);
        step();
        bus.load_valid = 1'b0;
        bus.data_rd_wr = 1'b1;
        bus.instr_addr = w(3);
        push(1'b1, "t3_readback",       32'h1234_5678);
        push(1'b0, "t3_load_not_taken", 32'd0);
        step();

        // Same word read on port A and written on port B
        bus.instr_addr = w(2);
        bus.data_addr  = w(2);
        bus.data_rd_wr = 1'b0;
        bus.data_out   = 32'hA5A5_A5A5;
        push(1'b0, "t4_rbw_old_word", 32'h2222_2222);
        push(1'b1, "t4_data_in_wr",   32'd0);
        step();
        bus.data_rd_wr = 1'b1;
        push(1'b0, "t4_instr_new_word", 32'hA5A5_A5A5);
        push(1'b1, "t4_data_new_word",  32'hA5A5_A5A5);
        step();
        chk("t4_no_err", 32'(bus.err), 32'd0);

        // Misaligned read, then clear racing a new write error
        bus.instr_addr = BASE;
        bus.data_addr  = BASE + 32'd2;
        push(1'b1, "t5_poison",      32'hDEAD_BEEF);
        push(1'b0, "t5_instr_valid", 32'h2402_0005);
        step();
        chk("t5_err_set",  32'(bus.err), 32'd1);
        chk("t5_err_addr", bus.err_addr, BASE + 32'd2);
        bus.data_rd_wr = 1'b0;
        bus.data_addr  = 32'h7000_0000;
        bus.data_out   = 32'hFFFF_FFFF;
        bus.err_clr    = 1'b1;
        push(1'b1, "t5_bad_wr_data_in", 32'd0);
        step();
        chk("t5_err_wins_clr", 32'(bus.err), 32'd1);
        chk("t5_err_addr_new", bus.err_addr, 32'h7000_0000);
        bus.data_rd_wr = 1'b1;
        bus.data_addr  = BASE;
        push(1'b0, "t5_bad_wr_dropped", 32'h2402_0005);
        step();
        chk("t5_err_cleared",  32'(bus.err), 32'd0);
        chk("t5_err_addr_clr", bus.err_addr, 32'd0);
        bus.err_clr = 1'b0;

        // Error priority: data over load over instr
        bus.instr_addr = BASE + 32'd1;
        bus.data_addr  = BASE + 32'h40;
        push(1'b0, "prio_instr_poison", 32'hDEAD_BEEF);
        push(1'b1, "prio_data_poison",  32'hDEAD_BEEF);
        step();
        chk("prio_data_over_instr", bus.err_addr, BASE + 32'h40);
        bus.data_addr  = BASE;
        bus.load_valid = 1'b1;
        bus.load_addr  = BASE - 32'd4;
        bus.load_data  = 32'h5555_5555;
        step();
        chk("prio_load_over_instr", bus.err_addr, BASE - 32'd4);
        bus.load_valid = 1'b0;
        step();
        chk("instr_err_addr", bus.err_addr, BASE + 32'd1);
        bus.instr_addr = BASE;
        bus.err_clr    = 1'b1;
        step();
        bus.err_clr    = 1'b0;
        chk("prio_err_cleared", 32'(bus.err), 32'd0);
        bus.data_addr = w(15);
        push(1'b1, "bad_load_dropped", 32'hCAFE_F00D);
        step();

        // Async reset from RUN, then reset again mid-sweep
        bus.data_addr = BASE + 32'd2;
        push(1'b0, "t6_pre_instr", 32'h2402_0005);
        push(1'b1, "t6_pre_data",  32'hDEAD_BEEF);
        step();
        bus.data_addr = BASE;
        reset = 1'b0;
        #1;
        chk("t6_async_instr_in",  bus.instr_in,       32'd0);
        chk("t6_async_data_in",   bus.data_in,        32'd0);
        chk("t6_async_err",       32'(bus.err),       32'd0);
        chk("t6_async_err_addr",  bus.err_addr,       32'd0);
        chk("t6_async_mem_ready", 32'(bus.mem_ready), 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        reset = 1'b0;
        #1;
        chk("t6_mid_mem_ready",  32'(bus.mem_ready),  32'd0);
        chk("t6_mid_load_ready", 32'(bus.load_ready), 32'd0);
        step();
        reset = 1'b1;
        wait_clear("t6_restart_len");
        bus.data_addr  = w(15);
        bus.instr_addr = w(4);
        push(1'b1, "t6_word15_zero", 32'd0);
        push(1'b0, "t6_word4_zero",  32'd0);
        step();
        bus.data_addr  = w(2);
        bus.instr_addr = BASE;
        push(1'b1, "t6_word2_zero", 32'd0);
        push(1'b0, "t6_word0_zero", 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
